ps2_tx: RTL and testbench

- PS/2 host-to-device transmitter.
- Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) to a keyboard over the shared open-collector ps2c/ps2d lines.
- Sits beside the PS/2 receiver on the same pins. Its tx_idle output gates the receiver's rx_en so the receiver ignores bus activity while a transmission is in progress.

---
 rtl/ps2_tx.sv | 149 ++++++++++++++
 tb/tb_ps2_tx.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device command transmitter on shared open-collector ps2c/ps2d lines.
// Optional acknowledge checking is enabled by defining PS2_TX_ACK_CHECK_EN.  Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module ps2_tx #(
  parameter int RTS_CYCLES = 13000,
  parameter int RTS_W      = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_ack_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RTS   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_ACK   = 3'd5;

  logic [2:0]       state, state_next;
  logic [7:0]       filter_reg, filter_next;
  logic             f_reg, f_next;
  logic             fall_edge;
  logic [8:0]       b_reg, b_next;
  logic [3:0]       n_reg, n_next;
  logic [RTS_W-1:0] c_reg, c_next;
  logic             c_en, d_en, d_out;

  // Glitch filter: the clock only changes after eight identical samples.
  assign filter_next = {ps2c, filter_reg[7:1]};
  assign f_next      = (filter_next == 8'hFF) ? 1'b1 :
                       (filter_next == 8'h00) ? 1'b0 : f_reg;
  assign fall_edge   = f_reg & ~f_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      filter_reg <= '0;
      f_reg      <= 1'b0;
      b_reg      <= '0;
      n_reg      <= '0;
      c_reg      <= '0;
    end else begin
      state      <= state_next;
      filter_reg <= filter_next;
      f_reg      <= f_next;
      b_reg      <= b_next;
      n_reg      <= n_next;
      c_reg      <= c_next;
    end
  end

  always_comb begin
    state_next = state;
    b_next     = b_reg;
    n_next     = n_reg;
    c_next     = c_reg;
    case (state)
      S_IDLE: begin
        if (wr_ps2) begin
          b_next     = {~^din, din};
          c_next     = RTS_W'(RTS_CYCLES - 1);
          state_next = S_RTS;
        end
      end
      S_RTS: begin
        c_next = c_reg - 1'b1;
        if (c_reg == '0) state_next = S_START;
      end
      S_START: begin
        if (fall_edge) begin
          n_next     = 4'd8;
          state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (fall_edge) begin
          b_next = {1'b0, b_reg[8:1]};
          if (n_reg == 4'd0) state_next = S_STOP;
          else               n_next     = n_reg - 1'b1;
        end
      end
      S_STOP: begin
        if (fall_edge) state_next = S_ACK;
      end
      S_ACK: begin
        if (fall_edge) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_idle      = 1'b0;
    tx_done_tick = 1'b0;
    c_en         = 1'b0;
    d_en         = 1'b0;
    d_out        = 1'b0;
    case (state)
      S_IDLE:  tx_idle = 1'b1;
      S_RTS:   c_en    = 1'b1;
      S_START: d_en    = 1'b1;
      S_DATA: begin
        d_en  = 1'b1;
        d_out = b_reg[0];
      end
      S_ACK:   tx_done_tick = fall_edge;
      default: ;
    endcase
  end

  assign ps2c = c_en ? 1'b0  : 1'bz;
  assign ps2d = d_en ? d_out : 1'bz;

`ifdef PS2_TX_ACK_CHECK_EN
  logic [1:0] d_sync;
  logic       ack_err_reg;
  logic       ack_miss;

  // A high data line at the acknowledge edge means the device never pulled it low.
  assign ack_miss = (state == S_ACK) && fall_edge && d_sync[1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      d_sync      <= '0;
      ack_err_reg <= 1'b0;
    end else begin
      d_sync <= {d_sync[0], ps2d};
      if (state == S_IDLE && wr_ps2) ack_err_reg <= 1'b0;
      else if (ack_miss)             ack_err_reg <= 1'b1;
    end
  end

  assign tx_ack_err = ack_err_reg | ack_miss;
`else
  assign tx_ack_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_tx.sv
// tb_ps2_tx: directed bench for ps2_tx with a behavioural PS/2 keyboard on pulled-up lines.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_tx;

  localparam int RTS = 20;
  localparam int H   = 40;  // device half clock period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  wire        ps2c;
  wire        ps2d;
  logic       tx_idle, tx_done_tick, tx_ack_err;
  logic       dev_c_low, dev_d_low;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_tx #(.RTS_CYCLES(RTS), .RTS_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .tx_ack_err   (tx_ack_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done_tick) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // inject: 0 none, 1 busy write mid-data, 2 reset after the 4th data bit
  task automatic run_frame(input string nm, input logic [7:0] byte_v, input logic exp_par,
                           input int inject, input bit ack_good, input bit exp_err);
    int         rts_len;
    int         d0;
    bit         seen;
    logic [10:0] bits;
    d0 = done_cnt;
    @(negedge clk); wr_ps2 = 1'b1; din = byte_v;
    @(negedge clk); wr_ps2 = 1'b0; din = 8'h00;
    check({nm, ":idle_drop"}, 32'(tx_idle), 32'd0);
    check({nm, ":err_clr"},   32'(tx_ack_err), 32'd0);
    rts_len = 0;
    while (ps2c === 1'b0 && rts_len < 1000) begin
      rts_len++;
      @(negedge clk);
    end
    check({nm, ":rts_len"}, 32'(rts_len), 32'(RTS));
    repeat (H) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      bits[i] = ps2d;
      if (inject == 1 && i == 4) begin
        wr_ps2 = 1'b1; din = 8'h55;
        @(negedge clk); wr_ps2 = 1'b0; din = 8'h00;
      end
      if (inject == 2 && i == 4) begin
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        check({nm, ":abort_c"},    32'(ps2c), 32'd1);
        check({nm, ":abort_d"},    32'(ps2d), 32'd1);
        check({nm, ":abort_idle"}, 32'(tx_idle), 32'd1);
        repeat (3 * H) @(negedge clk);
        check({nm, ":abort_done"}, 32'(done_cnt - d0), 32'd0);
        return;
      end
      dev_c_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_c_low = 1'b0;
      repeat (H) @(negedge clk);
    end
    dev_d_low = ack_good;
    repeat (4) @(negedge clk);
    dev_c_low = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (tx_done_tick) begin
        seen = 1'b1;
        check({nm, ":ack_err"},   32'(tx_ack_err), 32'(exp_err));
        check({nm, ":idle_tick"}, 32'(tx_idle), 32'd0);
        @(negedge clk);
        check({nm, ":idle_back"}, 32'(tx_idle), 32'd1);
        check({nm, ":err_hold"},  32'(tx_ack_err), 32'(exp_err));
      end
    end
    check({nm, ":tick_seen"}, 32'(seen), 32'd1);
    repeat (H) @(negedge clk);
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    repeat (H) @(negedge clk);
    check({nm, ":start"},  32'(bits[0]), 32'd0);
    check({nm, ":data"},   32'(bits[8:1]), 32'(byte_v));
    check({nm, ":parity"}, 32'(bits[9]), 32'(exp_par));
    check({nm, ":stop"},   32'(bits[10]), 32'd1);
    check({nm, ":ticks"},  32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lows;
    reset = 1'b0; wr_ps2 = 1'b1; din = 8'hF4;
    dev_c_low = 1'b0; dev_d_low = 1'b0;
    repeat (3) @(negedge clk);
    check("rst:idle", 32'(tx_idle), 32'd1);
    check("rst:ps2c", 32'(ps2c), 32'd1);
    check("rst:ps2d", 32'(ps2d), 32'd1);
    check("rst:tick", 32'(tx_done_tick), 32'd0);
    check("rst:err",  32'(tx_ack_err), 32'd0);
    wr_ps2 = 1'b0; reset = 1'b1;
    lows = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (ps2c === 1'b0 || !tx_idle) lows++;
    end
    check("rst:no_frame", 32'(lows), 32'd0);

    // 0xF4: popcount 5 -> odd parity bit 0; 0xED: popcount 6 -> parity bit 1
    run_frame("f4",   8'hF4, 1'b0, 0, 1'b1, 1'b0);
    run_frame("ed",   8'hED, 1'b1, 0, 1'b1, 1'b0);
    run_frame("busy", 8'hF4, 1'b0, 1, 1'b1, 1'b0);
    lows = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ps2c === 1'b0) lows++;
    end
    check("busy:no_second", 32'(lows), 32'd0);
    run_frame("abort", 8'hF4, 1'b0, 2, 1'b1, 1'b0);
    run_frame("after", 8'hF4, 1'b0, 0, 1'b1, 1'b0);
`ifdef PS2_TX_ACK_CHECK_EN
    run_frame("noack", 8'hF4, 1'b0, 0, 1'b0, 1'b1);
    run_frame("reack", 8'hF4, 1'b0, 0, 1'b1, 1'b0);
`else
    run_frame("noack", 8'hF4, 1'b0, 0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
